mem_access_unit: RTL

- Data-memory responder side of the control path: consumes the store byte-enable code (ram_we) and load-extension code (ram_ext_op) that the decoder produces for ld.*/st.* instructions.
- Drives a split-transaction SRAM-like data bus (addr_ok/data_ok handshake).
- Aligns write data and byte strobes; extracts and sign- or zero-extends read data.
- Sits between the EX/MEM pipeline boundary and the data bus; stalls the pipeline while an access is outstanding.

---
 rtl/mem_access_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: data-memory access unit between EX/MEM and a split-transaction
// SRAM-like bus. Aligns store data/strobes, extends load data, and flags
// misaligned accesses without touching the bus.
module mem_access_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              is_load,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [3:0]        ram_we,
  input  logic [2:0]        ram_ext_op,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              ale,
  output logic              busy,
  output logic              data_req,
  output logic              data_wr,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_t;

  state_t state_q, state_d;

  // Registered outputs
  logic              resp_valid_q, resp_valid_d;
  logic              ale_q, ale_d;
  logic              busy_q, busy_d;
  logic              data_req_q, data_req_d;
  logic              data_wr_q, data_wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [3:0]        data_wstrb_q, data_wstrb_d;
  logic [DATA_W-1:0] data_wdata_q, data_wdata_d;

  // Request fields needed after acceptance (load extraction)
  logic [1:0] lat_a_q, lat_a_d;
  logic [2:0] lat_ext_q, lat_ext_d;
  logic       lat_ld_q, lat_ld_d;

  logic       accept;
  size_t      req_sz;
  logic       misaligned;
  logic       noop;
  logic [7:0] rd_byte;
  logic [15:0] rd_half;
  logic [DATA_W-1:0] ld_result;

  assign req_ready = (state_q == S_IDLE);
  assign accept    = req_valid & req_ready;

  // Access size: loads decode ext code (5-7 treated as word), stores decode
  // the strobe code; unknown strobe codes collapse to "no access".
  always_comb begin
    req_sz = SZ_NONE;
    if (is_load) begin
      case (ram_ext_op)
        3'd1, 3'd2: req_sz = SZ_B;
        3'd3, 3'd4: req_sz = SZ_H;
        default:    req_sz = SZ_W;
      endcase
    end else begin
      case (ram_we)
        4'b0001: req_sz = SZ_B;
        4'b0011: req_sz = SZ_H;
        4'b1111: req_sz = SZ_W;
        default: req_sz = SZ_NONE;
      endcase
    end
  end

  assign misaligned = ((req_sz == SZ_H) & addr[0]) | ((req_sz == SZ_W) & (addr[1:0] != 2'b00));
  assign noop       = (req_sz == SZ_NONE);

  // Lane select and extension of the returned word, using the latched request
  always_comb begin
    rd_byte = data_rdata[{lat_a_q, 3'b000} +: 8];
    rd_half = lat_a_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (lat_ext_q)
      3'd1:    ld_result = {{24{rd_byte[7]}}, rd_byte};
      3'd2:    ld_result = {24'd0, rd_byte};
      3'd3:    ld_result = {{16{rd_half[15]}}, rd_half};
      3'd4:    ld_result = {16'd0, rd_half};
      default: ld_result = data_rdata;
    endcase
  end

  // State register
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic: only aligned, non-empty requests touch the bus
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && !noop && !misaligned) state_d = S_REQ;
      S_REQ:   if (data_addr_ok)                  state_d = S_WAIT;
      S_WAIT:  if (data_data_ok)                  state_d = S_IDLE;
      default:                                    state_d = S_IDLE;
    endcase
  end

  // Output next-state: bus fields are loaded at acceptance and held until done
  always_comb begin
    resp_valid_d = 1'b0;
    ale_d        = 1'b0;
    rdata_d      = '0;
    busy_d       = busy_q;
    data_req_d   = data_req_q;
    data_wr_d    = data_wr_q;
    data_addr_d  = data_addr_q;
    data_wstrb_d = data_wstrb_q;
    data_wdata_d = data_wdata_q;
    lat_a_d      = lat_a_q;
    lat_ext_d    = lat_ext_q;
    lat_ld_d     = lat_ld_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_a_d   = addr[1:0];
          lat_ext_d = ram_ext_op;
          lat_ld_d  = is_load;
          if (noop) begin
            resp_valid_d = 1'b1;
          end else if (misaligned) begin
            resp_valid_d = 1'b1;
            ale_d        = 1'b1;
          end else begin
            data_req_d  = 1'b1;
            busy_d      = 1'b1;
            data_wr_d   = ~is_load;
            data_addr_d = {addr[ADDR_W-1:2], 2'b00};
            if (is_load) begin
              data_wstrb_d = 4'b0000;
              data_wdata_d = '0;
            end else begin
              case (req_sz)
                SZ_B: begin
                  data_wstrb_d = 4'b0001 << addr[1:0];
                  data_wdata_d = {4{wdata[7:0]}};
                end
                SZ_H: begin
                  data_wstrb_d = 4'b0011 << addr[1:0];
                  data_wdata_d = {2{wdata[15:0]}};
                end
                default: begin
                  data_wstrb_d = 4'b1111;
                  data_wdata_d = wdata;
                end
              endcase
            end
          end
        end
      end
      S_REQ: begin
        if (data_addr_ok) data_req_d = 1'b0;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          resp_valid_d = 1'b1;
          busy_d       = 1'b0;
          rdata_d      = lat_ld_q ? ld_result : '0;
        end
      end
      default: ;
    endcase
  end

  // Output and latched-field registers
  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      resp_valid_q <= 1'b0;
      ale_q        <= 1'b0;
      busy_q       <= 1'b0;
      data_req_q   <= 1'b0;
      data_wr_q    <= 1'b0;
      rdata_q      <= '0;
      data_addr_q  <= '0;
      data_wstrb_q <= 4'b0000;
      data_wdata_q <= '0;
      lat_a_q      <= 2'b00;
      lat_ext_q    <= 3'd0;
      lat_ld_q     <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      ale_q        <= ale_d;
      busy_q       <= busy_d;
      data_req_q   <= data_req_d;
      data_wr_q    <= data_wr_d;
      rdata_q      <= rdata_d;
      data_addr_q  <= data_addr_d;
      data_wstrb_q <= data_wstrb_d;
      data_wdata_q <= data_wdata_d;
      lat_a_q      <= lat_a_d;
      lat_ext_q    <= lat_ext_d;
      lat_ld_q     <= lat_ld_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign ale        = ale_q;
  assign busy       = busy_q;
  assign data_req   = data_req_q;
  assign data_wr    = data_wr_q;
  assign rdata      = rdata_q;
  assign data_addr  = data_addr_q;
  assign data_wstrb = data_wstrb_q;
  assign data_wdata = data_wdata_q;

endmodule
